// File: rtl/pet2001_vram_arbiter.sv
// PET 2001 video RAM arbiter: one fixed video read slot per 1 us, CPU reads and posted writes fill the rest (PET_SNOW_EN: snow emulation).
// Read data returns 2 clk after issue on ram_*; writes ack next clk, and a write stalls (no ack) while the buffer is still full.
module pet2001_vram_arbiter #(
  parameter int VSLOT_PHASE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce_8mp,
  input  logic        ce_1m,
  input  logic [10:0] vid_addr,
  input  logic        vid_fetch_en,
  output logic [7:0]  vid_data,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [10:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rdata,
  output logic [10:0] ram_addr,
  output logic        ram_we,
  output logic [7:0]  ram_wdata,
  input  logic [7:0]  ram_rdata
);

  localparam logic [2:0] VSLOT = 3'(VSLOT_PHASE);

  typedef enum logic [2:0] {
    TAG_NONE,
    TAG_VID,
    TAG_CPU,
    TAG_SNOW_WR,
    TAG_SNOW_RD
  } tag_t;

  logic [2:0]  phase;
  logic        vslot;
  logic        vid_req;

  logic        wb_full;
  logic [10:0] wb_addr;
  logic [7:0]  wb_data;

  logic        rd_pend;
  logic        rd_busy;
  logic [10:0] rd_addr;

  tag_t        tag_q0;
  tag_t        tag_q1;
  tag_t        iss_tag;

  logic        cpu_idle;
  logic        wr_accept;
  logic        rd_hit;
  logic        rd_fwd;
  logic        rd_accept;
  logic        cpu_ret;

  logic        iss_vid;
  logic        iss_drain;
  logic        iss_rd;
  logic        snow;

`ifdef PET_SNOW_EN
  logic [7:0]  snow_d0;
  logic [7:0]  snow_d1;
`endif

  assign vslot   = ce_8mp && (phase == VSLOT);
  assign vid_req = vslot && vid_fetch_en;

  // The held request is still present in the ack cycle, so it must not be taken again then.
  assign cpu_idle  = !rd_busy && !cpu_ack;
  assign wr_accept = cpu_req && cpu_we && !wb_full && cpu_idle;
  assign rd_hit    = wb_full && (wb_addr == cpu_addr);
  assign rd_fwd    = cpu_req && !cpu_we && cpu_idle && rd_hit;
  assign rd_accept = cpu_req && !cpu_we && cpu_idle && !rd_hit;
  assign cpu_ret   = (tag_q1 == TAG_CPU) || (tag_q1 == TAG_SNOW_RD);

  always_comb begin
    iss_vid   = 1'b0;
    iss_drain = 1'b0;
    iss_rd    = 1'b0;
    snow      = 1'b0;
    iss_tag   = TAG_NONE;
`ifdef PET_SNOW_EN
    // A CPU op ready at the video slot steals it, as on the original board.
    if (vid_req && !(wb_full || rd_pend)) begin
      iss_vid = 1'b1;
    end else if (wb_full) begin
      iss_drain = 1'b1;
      snow      = vid_req;
    end else if (rd_pend) begin
      iss_rd = 1'b1;
      snow   = vid_req;
    end
`else
    if (vid_req) begin
      iss_vid = 1'b1;
    end else if (wb_full) begin
      iss_drain = 1'b1;
    end else if (rd_pend) begin
      iss_rd = 1'b1;
    end
`endif
    if (iss_vid) begin
      iss_tag = TAG_VID;
    end else if (iss_rd) begin
      iss_tag = snow ? TAG_SNOW_RD : TAG_CPU;
    end else if (iss_drain && snow) begin
      iss_tag = TAG_SNOW_WR;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase     <= 3'd0;
      ram_addr  <= 11'd0;
      ram_we    <= 1'b0;
      ram_wdata <= 8'd0;
      vid_data  <= 8'd0;
      cpu_ack   <= 1'b0;
      cpu_rdata <= 8'd0;
      wb_full   <= 1'b0;
      wb_addr   <= 11'd0;
      wb_data   <= 8'd0;
      rd_pend   <= 1'b0;
      rd_busy   <= 1'b0;
      rd_addr   <= 11'd0;
      tag_q0    <= TAG_NONE;
      tag_q1    <= TAG_NONE;
`ifdef PET_SNOW_EN
      snow_d0   <= 8'd0;
      snow_d1   <= 8'd0;
`endif
    end else begin
      if (ce_1m) begin
        phase <= 3'd0;
      end else if (ce_8mp) begin
        phase <= phase + 3'd1;
      end

      ram_we <= iss_drain;
      if (iss_vid) begin
        ram_addr <= vid_addr;
      end else if (iss_drain) begin
        ram_addr  <= wb_addr;
        ram_wdata <= wb_data;
      end else if (iss_rd) begin
        ram_addr <= rd_addr;
      end

      tag_q0 <= iss_tag;
      tag_q1 <= tag_q0;

      if (wr_accept) begin
        wb_full <= 1'b1;
        wb_addr <= cpu_addr;
        wb_data <= cpu_wdata;
      end else if (iss_drain) begin
        wb_full <= 1'b0;
      end

      if (cpu_ret) begin
        rd_busy <= 1'b0;
      end
      if (rd_accept) begin
        rd_pend <= 1'b1;
        rd_busy <= 1'b1;
        rd_addr <= cpu_addr;
      end else if (iss_rd) begin
        rd_pend <= 1'b0;
      end

      cpu_ack <= wr_accept || rd_fwd || cpu_ret;
      if (rd_fwd) begin
        cpu_rdata <= wb_data;
      end else if (cpu_ret) begin
        cpu_rdata <= ram_rdata;
      end

      if ((tag_q1 == TAG_VID) || (tag_q1 == TAG_SNOW_RD)) begin
        vid_data <= ram_rdata;
      end
`ifdef PET_SNOW_EN
      snow_d0 <= wb_data;
      snow_d1 <= snow_d0;
      if (tag_q1 == TAG_SNOW_WR) begin
        vid_data <= snow_d1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_pet2001_vram_arbiter.sv
// Directed bench for pet2001_vram_arbiter with a synchronous RAM model and a bench-side clock-enable schedule.
module tb_pet2001_vram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        ce_8mp;
  logic        ce_1m;
  logic [10:0] vid_addr;
  logic        vid_fetch_en;
  logic [7:0]  vid_data;
  logic        cpu_req;
  logic        cpu_we;
  logic [10:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic [10:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;

  int n_checks = 0;
  int n_pass   = 0;

  // ce schedule: ce_8mp every 4 clk, ce_1m on every 8th ce_8mp; slot is ce_8mp with pcnt==2
  logic       run  = 1'b0;
  logic [1:0] div  = 2'd0;
  logic [2:0] pcnt = 3'd0;

  logic [7:0] mem [0:2047];
  logic       mem_ready = 1'b0;

  pet2001_vram_arbiter #(.VSLOT_PHASE(1)) dut (
    .clk          (clk),
    .reset        (reset),
    .ce_8mp       (ce_8mp),
    .ce_1m        (ce_1m),
    .vid_addr     (vid_addr),
    .vid_fetch_en (vid_fetch_en),
    .vid_data     (vid_data),
    .cpu_req      (cpu_req),
    .cpu_we       (cpu_we),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_ack      (cpu_ack),
    .cpu_rdata    (cpu_rdata),
    .ram_addr     (ram_addr),
    .ram_we       (ram_we),
    .ram_wdata    (ram_wdata),
    .ram_rdata    (ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 2048; i++) begin
        mem[i] <= 8'(i) ^ 8'h5C;
      end
      mem[11'h123] <= 8'h41;
      mem[11'h7FF] <= 8'hE5;
      mem_ready    <= 1'b1;
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
    ram_rdata <= mem[ram_addr];
  end

  task automatic cyc();
    ce_8mp = run && (div == 2'd0);
    ce_1m  = ce_8mp && (pcnt == 3'd0);
    @(posedge clk);
    #1;
    if (ce_8mp) pcnt = pcnt + 3'd1;
    if (run) div = div + 2'd1;
  endtask

  function automatic int dist_to_slot();
    logic [1:0] d;
    logic [2:0] p;
    d = div;
    p = pcnt;
    for (int i = 0; i < 40; i++) begin
      if (d == 2'd0 && p == 3'd2) return i;
      if (d == 2'd0) p = p + 3'd1;
      d = d + 2'd1;
    end
    return -1;
  endfunction

  // Advance until the k-th upcoming cycle (0 = next) is the video slot.
  task automatic align(input int k);
    int guard;
    guard = 0;
    while (dist_to_slot() != k && guard < 64) begin
      cyc();
      guard++;
    end
    if (guard >= 64) begin
      n_checks++;
      $display("FAIL align: slot not reached in %0d cycles", guard);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic test_reset();
    reset = 1'b1; run = 1'b0; div = 2'd0; pcnt = 3'd0;
    vid_addr = 11'd0; vid_fetch_en = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 11'd0; cpu_wdata = 8'd0;
    idle(3);
    n_checks++; if (ram_addr !== 11'd0) $display("FAIL rst_ram_addr: got %h want 000", ram_addr); else n_pass++;
    n_checks++; if (ram_we !== 1'b0) $display("FAIL rst_ram_we: got %b want 0", ram_we); else n_pass++;
    n_checks++; if (ram_wdata !== 8'd0) $display("FAIL rst_ram_wdata: got %h want 00", ram_wdata); else n_pass++;
    n_checks++; if (vid_data !== 8'd0) $display("FAIL rst_vid_data: got %h want 00", vid_data); else n_pass++;
    n_checks++; if (cpu_ack !== 1'b0) $display("FAIL rst_cpu_ack: got %b want 0", cpu_ack); else n_pass++;
    n_checks++; if (cpu_rdata !== 8'd0) $display("FAIL rst_cpu_rdata: got %h want 00", cpu_rdata); else n_pass++;
    reset = 1'b0; run = 1'b1;
  endtask

  task automatic test_video_fetch();
    int changes;
    logic [10:0] prev;
    vid_fetch_en = 1'b1; vid_addr = 11'h123;
    align(0);
    cyc();
    n_checks++; if (ram_addr !== 11'h123) $display("FAIL vid_ram_addr: got %h want 123", ram_addr); else n_pass++;
    n_checks++; if (ram_we !== 1'b0) $display("FAIL vid_ram_we: got %b want 0", ram_we); else n_pass++;
    cyc();
    n_checks++; if (vid_data !== 8'h00) $display("FAIL vid_data_early: got %h want 00", vid_data); else n_pass++;
    cyc();
    n_checks++; if (vid_data !== 8'h41) $display("FAIL vid_data: got %h want 41", vid_data); else n_pass++;

    // Slot with fetch disabled: no RAM op, vid_data holds.
    vid_fetch_en = 1'b0; vid_addr = 11'h555;
    align(0);
    idle(3);
    n_checks++; if (ram_addr !== 11'h123) $display("FAIL nofetch_ram_addr: got %h want 123", ram_addr); else n_pass++;
    n_checks++; if (vid_data !== 8'h41) $display("FAIL nofetch_vid_data: got %h want 41", vid_data); else n_pass++;

    // 64 clk = 16 ce_8mp = two character periods: exactly two video loads.
    vid_fetch_en = 1'b1;
    changes = 0;
    prev = 11'h123;
    for (int i = 0; i < 64; i++) begin
      vid_addr = 11'h400 + 11'(i);
      cyc();
      if (ram_addr !== prev) changes++;
      prev = ram_addr;
    end
    n_checks++; if (changes !== 2) $display("FAIL vid_read_rate: got %0d reads want 2", changes); else n_pass++;
    vid_addr = 11'h123;
    idle(4);
  endtask

  task automatic test_write_at_vslot();
    vid_fetch_en = 1'b1; vid_addr = 11'h123;
    align(0);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 11'h010; cpu_wdata = 8'h5A;
    cyc();
    n_checks++; if (cpu_ack !== 1'b1) $display("FAIL wr_ack: got %b want 1", cpu_ack); else n_pass++;
    n_checks++; if (ram_addr !== 11'h123) $display("FAIL wr_vid_first: got %h want 123", ram_addr); else n_pass++;
    n_checks++; if (ram_we !== 1'b0) $display("FAIL wr_we_early: got %b want 0", ram_we); else n_pass++;
    cpu_req = 1'b0;
    cyc();
    n_checks++; if (ram_we !== 1'b1) $display("FAIL wr_we: got %b want 1", ram_we); else n_pass++;
    n_checks++; if (ram_addr !== 11'h010) $display("FAIL wr_addr: got %h want 010", ram_addr); else n_pass++;
    n_checks++; if (ram_wdata !== 8'h5A) $display("FAIL wr_wdata: got %h want 5a", ram_wdata); else n_pass++;
    n_checks++; if (cpu_ack !== 1'b0) $display("FAIL wr_ack_pulse: got %b want 0", cpu_ack); else n_pass++;
    cyc();
    n_checks++; if (ram_we !== 1'b0) $display("FAIL wr_we_single: got %b want 0", ram_we); else n_pass++;
    n_checks++; if (mem[11'h010] !== 8'h5A) $display("FAIL wr_mem: got %h want 5a", mem[11'h010]); else n_pass++;
    idle(3);
  endtask

`ifndef PET_SNOW_EN
  // The slot delays the drain, so the following read finds the buffer still full.
  task automatic test_forward();
    vid_fetch_en = 1'b1; vid_addr = 11'h123;
    align(1);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 11'h200; cpu_wdata = 8'h3C;
    cyc();
    n_checks++; if (cpu_ack !== 1'b1) $display("FAIL fwd_wr_ack: got %b want 1", cpu_ack); else n_pass++;
    cpu_req = 1'b0;
    cyc();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h200;
    cyc();
    n_checks++; if (cpu_ack !== 1'b1) $display("FAIL fwd_ack: got %b want 1", cpu_ack); else n_pass++;
    n_checks++; if (cpu_rdata !== 8'h3C) $display("FAIL fwd_rdata: got %h want 3c", cpu_rdata); else n_pass++;
    n_checks++; if (ram_we !== 1'b1 || ram_addr !== 11'h200) $display("FAIL fwd_drain: got we=%b addr=%h want we=1 addr=200", ram_we, ram_addr); else n_pass++;
    cpu_req = 1'b0;
    idle(2);
    n_checks++; if (ram_addr !== 11'h200) $display("FAIL fwd_no_read: got addr %h want 200", ram_addr); else n_pass++;
    n_checks++; if (cpu_ack !== 1'b0) $display("FAIL fwd_no_extra_ack: got %b want 0", cpu_ack); else n_pass++;
    idle(3);
  endtask

  task automatic test_read_vslot();
    vid_fetch_en = 1'b1; vid_addr = 11'h123;
    align(1);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h0AB;
    idle(2);
    n_checks++; if (ram_addr !== 11'h123) $display("FAIL rdv_vid_first: got %h want 123", ram_addr); else n_pass++;
    cyc();
    n_checks++; if (ram_addr !== 11'h0AB) $display("FAIL rdv_addr: got %h want 0ab", ram_addr); else n_pass++;
    idle(2);
    n_checks++; if (cpu_ack !== 1'b1 || cpu_rdata !== 8'hF7) $display("FAIL rdv_ack: got ack=%b data=%h want ack=1 data=f7", cpu_ack, cpu_rdata); else n_pass++;
    cpu_req = 1'b0;
    idle(3);
  endtask
`endif

  task automatic test_cpu_read();
    vid_fetch_en = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h7FF;
    cyc();
    n_checks++; if (cpu_ack !== 1'b0) $display("FAIL rd_ack_early1: got %b want 0", cpu_ack); else n_pass++;
    cyc();
    n_checks++; if (ram_addr !== 11'h7FF || ram_we !== 1'b0) $display("FAIL rd_issue: got addr=%h we=%b want 7ff/0", ram_addr, ram_we); else n_pass++;
    cyc();
    n_checks++; if (cpu_ack !== 1'b0) $display("FAIL rd_ack_early2: got %b want 0", cpu_ack); else n_pass++;
    cyc();
    n_checks++; if (cpu_ack !== 1'b1) $display("FAIL rd_ack: got %b want 1", cpu_ack); else n_pass++;
    n_checks++; if (cpu_rdata !== 8'hE5) $display("FAIL rd_rdata: got %h want e5", cpu_rdata); else n_pass++;
    cpu_req = 1'b0;
    cyc();
    n_checks++; if (cpu_ack !== 1'b0) $display("FAIL rd_ack_pulse: got %b want 0", cpu_ack); else n_pass++;
    idle(3);
  endtask

  task automatic test_snow_collision();
    logic       exp_we_v1;
    logic [7:0] exp_vid;
`ifdef PET_SNOW_EN
    exp_we_v1 = 1'b1; exp_vid = 8'h99;
`else
    exp_we_v1 = 1'b0; exp_vid = 8'hF7;
`endif
    vid_fetch_en = 1'b1; vid_addr = 11'h0AB;
    align(1);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 11'h300; cpu_wdata = 8'h99;
    cyc();
    cpu_req = 1'b0;
    cyc();
    n_checks++; if (ram_we !== exp_we_v1) $display("FAIL snow_we_slot: got %b want %b", ram_we, exp_we_v1); else n_pass++;
    cyc();
    n_checks++; if (ram_we !== !exp_we_v1) $display("FAIL snow_we_next: got %b want %b", ram_we, !exp_we_v1); else n_pass++;
    cyc();
    n_checks++; if (vid_data !== exp_vid) $display("FAIL snow_vid_data: got %h want %h", vid_data, exp_vid); else n_pass++;
    n_checks++; if (mem[11'h300] !== 8'h99) $display("FAIL snow_mem: got %h want 99", mem[11'h300]); else n_pass++;
    idle(3);
  endtask

  task automatic test_reset_midflight();
    int acks;
    vid_fetch_en = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h7FF;
    idle(2);
    reset = 1'b1; cpu_req = 1'b0; run = 1'b0; div = 2'd0; pcnt = 3'd0;
    cyc();
    n_checks++; if (ram_addr !== 11'd0) $display("FAIL mid_ram_addr: got %h want 000", ram_addr); else n_pass++;
    n_checks++; if (ram_we !== 1'b0) $display("FAIL mid_ram_we: got %b want 0", ram_we); else n_pass++;
    n_checks++; if (ram_wdata !== 8'd0) $display("FAIL mid_ram_wdata: got %h want 00", ram_wdata); else n_pass++;
    n_checks++; if (vid_data !== 8'd0) $display("FAIL mid_vid_data: got %h want 00", vid_data); else n_pass++;
    n_checks++; if (cpu_ack !== 1'b0) $display("FAIL mid_cpu_ack: got %b want 0", cpu_ack); else n_pass++;
    n_checks++; if (cpu_rdata !== 8'd0) $display("FAIL mid_cpu_rdata: got %h want 00", cpu_rdata); else n_pass++;
    reset = 1'b0; run = 1'b1;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (cpu_ack === 1'b1) acks++;
    end
    n_checks++; if (acks !== 0) $display("FAIL mid_no_ack: got %0d acks want 0", acks); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_video_fetch();
    test_write_at_vslot();
`ifndef PET_SNOW_EN
    test_forward();
`endif
    test_cpu_read();
`ifndef PET_SNOW_EN
    test_read_vslot();
`endif
    test_snow_collision();
    test_reset_midflight();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
